pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, PC width in bits.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, first fetch address after start, truncated to ADDR_W.
REQ-003 Parameter INSTR_BYTES, default 4, sequential increment; power of two, 1..8.
REQ-004 Parameter CNT_W, default 32, fetch-counter width.
REQ-005 clk_i  in  1  sole clock; all state on rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 start_i  in  1  one-shot run request, honoured only in IDLE.
REQ-008 stall_i  in  1  hazard-detect hold request; PC frozen while high.
REQ-009 redirect_i  in  1  branch/jump taken, from the resolving stage.
REQ-010 redirect_pc_i  in  ADDR_W  branch/jump target.
REQ-011 pc_o  out  ADDR_W  current fetch address (registered).
REQ-012 pc_next_o  out  ADDR_W  pc_o + INSTR_BYTES, combinational, modulo 2^ADDR_W.
REQ-013 valid_o  out  1  pc_o is a live fetch address this cycle.
REQ-014 fetch_cnt_o  out  CNT_W  number of cycles with valid_o=1 and stall_i=0.
REQ-015 state_o  out  2  FSM state: IDLE=0, RUN=1, STALL=2, HALT=3.
REQ-016 align_err_o  out  1  sticky misaligned-redirect flag.

Function
REQ-017 FSM SHALL have states IDLE, RUN, STALL and HALT; HALT is reachable only under REQ-031.
REQ-018 IDLE: pc_o=RESET_VEC, valid_o=0; redirect_i and stall_i ignored; start_i=1 -> RUN next cycle with pc_o=RESET_VEC.
REQ-019 start_i SHALL be ignored in every state except IDLE; a second start pulse never reloads RESET_VEC.
REQ-020 RUN/STALL priority per cycle SHALL be: redirect_i, then stall_i, then sequential increment.
REQ-021 redirect_i=1 in RUN or STALL -> pc_o=redirect_pc_i next cycle, state RUN, even if stall_i=1.
REQ-022 stall_i=1 (no redirect) -> pc_o unchanged, state STALL; stall_i=0 in STALL -> pc_o=pc_o+INSTR_BYTES, state RUN.
REQ-023 No redirect, no stall, state RUN -> pc_o=pc_o+INSTR_BYTES next cycle (one-cycle latency).
REQ-024 Increment SHALL wrap modulo 2^ADDR_W with no flag (e.g. all-ones-minus-3 + 4 -> 0 for ADDR_W=32).
REQ-025 valid_o SHALL be 1 in RUN and STALL, 0 in IDLE and HALT.
REQ-026 fetch_cnt_o SHALL increment by 1 on each edge where valid_o=1 and stall_i=0, and wrap modulo 2^CNT_W.

Reset
REQ-027 rst_i=1 at a clock edge SHALL force IDLE, pc_o=RESET_VEC, fetch_cnt_o=0, align_err_o=0 regardless of other inputs.
REQ-028 Reset asserted mid-RUN, mid-STALL or in HALT SHALL discard all pending redirect/stall; start_i is required again to run.
REQ-029 start_i sampled in the same cycle as rst_i=1 SHALL be ignored.

Configuration
REQ-030 Macro PC_ALIGN_CHECK_EN SHALL select redirect alignment checking.
REQ-031 Defined: redirect with redirect_pc_i[log2(INSTR_BYTES)-1:0] != 0 SHALL NOT load pc_o; align_err_o=1 (sticky until reset), state HALT, pc_o held at the last valid value.
REQ-032 Undefined: low log2(INSTR_BYTES) bits of redirect_pc_i are forced to 0 on load; align_err_o tied 0; HALT unreachable.
REQ-033 With INSTR_BYTES=1, the check SHALL never fire in either build.

Verification
REQ-034 Reset, start_i pulse, 3 idle cycles -> pc_o 0,4,8,12; valid_o=1 from the first; fetch_cnt_o=4.
REQ-035 RUN at pc=0x10, stall_i high for 2 cycles -> pc_o 0x10,0x10,0x10,0x14; state_o 2,2,1; fetch_cnt_o frozen during the stall.
REQ-036 redirect_i=1 with redirect_pc_i=0x200 and stall_i=1 at pc=0x20 -> pc_o=0x200 next cycle, state RUN.
REQ-037 pc=0xFFFF_FFFC, no stall -> pc_o=0x0, pc_next_o=0x4; start_i pulse mid-RUN -> no effect.
REQ-038 redirect_pc_i=0x102: with PC_ALIGN_CHECK_EN -> align_err_o=1, state HALT, valid_o=0, pc_o held; without it -> pc_o=0x100.
REQ-039 rst_i pulse mid-STALL with start_i=1 in the same cycle -> IDLE, pc_o=0, fetch_cnt_o=0, and no RUN until the next start_i.

Source files
------------

// File: rtl/pc_ctrl.sv
// pc_ctrl -- program-counter sequencer for an in-order fetch stage.
//
// Holds the fetch address, steps it by INSTR_BYTES each cycle while
// running, holds it while the hazard unit asks for a stall, and loads a
// branch/jump target when the resolving stage redirects. It also counts
// the cycles that issue a fetch.
//
// Build option: define PC_ALIGN_CHECK_EN to check redirect targets for
// alignment. With the check, a misaligned target is not loaded. Instead
// align_err_o is set and the sequencer parks in HALT until the next reset.
// Without the check, the low address bits of the target are cleared and
// align_err_o stays 0.
//
// Ports
//   clk_i          sole clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        run request, honoured only in IDLE
//   stall_i        hold request; PC frozen while high
//   redirect_i     branch/jump taken
//   redirect_pc_i  branch/jump target
//   pc_o           current fetch address (registered)
//   pc_next_o      pc_o + INSTR_BYTES (combinational, wraps)
//   valid_o        pc_o is a live fetch address
//   fetch_cnt_o    count of cycles with valid_o=1 and stall_i=0
//   state_o        FSM state
//   align_err_o    sticky misaligned-redirect flag
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start_i, pc_o parked at RESET_VEC, no fetch
// RUN   | fetching, pc_o advances or is redirected each cycle
// STALL | fetching, pc_o held by stall_i
// HALT  | stopped after a misaligned redirect, left only by reset

module pc_ctrl #(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
    parameter int          INSTR_BYTES = 4,
    parameter int          CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  fetch_cnt_o,
    output logic [1:0]        state_o,
    output logic              align_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [ADDR_W-1:0] RST_PC     = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
    // The low log2(INSTR_BYTES) bits. This is zero when INSTR_BYTES=1,
    // so in that case the alignment check can never fire.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              redirect_ok;
    logic [ADDR_W-1:0] redirect_tgt;
    logic              active;

    assign active = (state_q == S_RUN) || (state_q == S_STALL);

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    logic align_err_q;

    assign misaligned   = |(redirect_pc_i & ALIGN_MASK);
    assign redirect_ok  = ~misaligned;
    assign redirect_tgt = redirect_pc_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            align_err_q <= 1'b0;
        end else if (active && redirect_i && misaligned) begin
            align_err_q <= 1'b1;
        end
    end

    assign align_err_o = align_err_q;
`else
    assign redirect_ok  = 1'b1;
    assign redirect_tgt = redirect_pc_i & ~ALIGN_MASK;
    assign align_err_o  = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. Priority is redirect, then stall, then increment.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN, S_STALL: begin
                if (redirect_i) begin
                    state_d = redirect_ok ? S_RUN : S_HALT;
                end else if (stall_i) begin
                    state_d = S_STALL;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // Outputs
    always_comb begin
        valid_o = active;
        state_o = state_q;
    end

    // Datapath next values
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (active && !stall_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        case (state_q)
            S_IDLE: pc_d = RST_PC;
            S_RUN, S_STALL: begin
                if (redirect_i) begin
                    if (redirect_ok) begin
                        pc_d = redirect_tgt;
                    end
                end else if (!stall_i) begin
                    pc_d = pc_q + INC;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RST_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc_o        = pc_q;
    assign pc_next_o   = pc_q + INC;
    assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl with default parameters (32-bit PC, 4-byte step,
// reset vector 0). It runs directed scenarios first and then randomized
// traffic. A cycle-level reference model is checked after every edge.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, stall, redir;
    logic [31:0] redir_pc;
    logic [31:0] pc, pc_next, cnt;
    logic        valid, align_err;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .stall_i      (stall),
        .redirect_i   (redir),
        .redirect_pc_i(redir_pc),
        .pc_o         (pc),
        .pc_next_o    (pc_next),
        .valid_o      (valid),
        .fetch_cnt_o  (cnt),
        .state_o      (state),
        .align_err_o  (align_err)
    );

`ifdef PC_ALIGN_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: 0 idle, 1 run, 2 stall, 3 halt
    int          m_state = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_cnt   = 32'h0;
    bit          m_err   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_state = 0; m_pc = 32'h0; m_cnt = 0; m_err = 0;
        end else if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state == 1 || m_state == 2) begin
            if (!stall) m_cnt = m_cnt + 1;
            if (redir) begin
                if (CHECK_EN && (redir_pc % 4) != 0) begin
                    m_state = 3; m_err = 1;
                end else begin
                    m_pc = redir_pc - (redir_pc % 4);
                    m_state = 1;
                end
            end else if (stall) begin
                m_state = 2;
            end else begin
                m_pc = m_pc + 4;
                m_state = 1;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_next;
        exp_next = m_pc + 32'd4;
        chk("pc", pc, m_pc);
        chk("pc_next", pc_next, exp_next);
        chk("valid", valid, (m_state == 1 || m_state == 2));
        chk("fetch_cnt", cnt, m_cnt);
        chk("state", state, m_state);
        chk("align_err", align_err, m_err);
    endtask

    task automatic drive(input bit r, input bit s, input bit st, input bit rd,
                         input logic [31:0] rpc);
        rst = r; start = s; stall = st; redir = rd; redir_pc = rpc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    logic [31:0] saved, rnd;
    bit          r_rst, r_start, r_stall, r_redir;

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        @(negedge clk);

        // Reset state, with redirect/stall/start all driven high
        drive(1, 1, 1, 1, 32'h40);
        chk("rst_pc", pc, 32'h0);
        chk("rst_state", state, 2'd0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_cnt", cnt, 32'h0);

        // IDLE ignores redirect and stall
        drive(0, 0, 1, 1, 32'h80);
        chk("idle_pc", pc, 32'h0);

        // Start, then sequential fetch
        drive(0, 1, 0, 0, 0);
        chk("start_pc", pc, 32'h0);
        chk("start_valid", valid, 1'b1);
        drive(0, 0, 0, 0, 0); chk("seq_pc4", pc, 32'h4);
        drive(0, 0, 0, 0, 0); chk("seq_pc8", pc, 32'h8);
        drive(0, 0, 0, 0, 0); chk("seq_pc12", pc, 32'hC);
        drive(0, 0, 0, 0, 0); chk("seq_cnt4", cnt, 32'd4);

        // Stall at 0x10 for two cycles
        drive(0, 0, 0, 1, 32'h10);
        saved = cnt;
        drive(0, 0, 1, 0, 0); chk("stall1_pc", pc, 32'h10); chk("stall1_st", state, 2'd2);
        drive(0, 0, 1, 0, 0); chk("stall2_pc", pc, 32'h10); chk("stall2_st", state, 2'd2);
        chk("stall_cnt_frozen", cnt, saved);
        drive(0, 0, 0, 0, 0); chk("unstall_pc", pc, 32'h14); chk("unstall_st", state, 2'd1);

        // Redirect wins over stall
        drive(0, 0, 0, 1, 32'h20);
        drive(0, 0, 1, 1, 32'h200);
        chk("redir_stall_pc", pc, 32'h200);
        chk("redir_stall_st", state, 2'd1);

        // Wraparound, and a start pulse in the middle of RUN
        drive(0, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_next", pc_next, 32'h0);
        drive(0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_next4", pc_next, 32'h4);
        drive(0, 1, 0, 0, 0);
        chk("restart_ignored", pc, 32'h4);

        // Misaligned redirect
        saved = pc;
        drive(0, 0, 0, 1, 32'h102);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_err", align_err, 1'b1);
        chk("mis_state", state, 2'd3);
        chk("mis_valid", valid, 1'b0);
        chk("mis_pc_held", pc, saved);
        drive(0, 1, 0, 1, 32'h300);
        chk("halt_sticky", state, 2'd3);
`else
        chk("mis_pc", pc, 32'h100);
        chk("mis_err", align_err, 1'b0);
`endif

        // Reset in the middle of STALL, with start asserted in the same cycle
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(1, 1, 1, 1, 32'h40);
        chk("rst_stall_state", state, 2'd0);
        chk("rst_stall_pc", pc, 32'h0);
        chk("rst_stall_cnt", cnt, 32'h0);
        drive(0, 0, 0, 0, 0);
        chk("no_auto_run", state, 2'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_rst   = ($urandom_range(0, 39) == 0);
            r_start = ($urandom_range(0, 7) == 0);
            r_stall = ($urandom_range(0, 3) == 0);
            r_redir = ($urandom_range(0, 5) == 0);
            rnd = $urandom();
            case ($urandom_range(0, 9))
                0:       rnd = rnd;
                1:       rnd = 32'hFFFF_FFF8 | (rnd & 32'h4);
                default: rnd = rnd & 32'hFFFF_FFFC;
            endcase
            drive(r_rst, r_start, r_stall, r_redir, rnd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
